store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
// - FIFO write buffer between the MEM-stage store path and the data memory (DM) port.
// - Accepts sw/sh/sb requests at one per cycle and drains one per cycle into DM whenever DM is not busy with a load.
// - Flags load hazards against pending entries so the pipeline stalls, or forwards data when possible.
// - Provides an empty flag so the pipeline can fence stores before halt or syscall.
// PARAMETERS
// - DEPTH   4   entry count; power of 2, >= 2
// - PTR_W   2   log2(DEPTH); must be consistent with DEPTH
// PORTS
// - clk          in   1   clock; all state updates on posedge
// - reset        in   1   synchronous, active-high
// - st_valid     in   1   store request this cycle
// - st_addr      in   32  byte address of the store
// - st_wd        in   32  store data, right-aligned for sh/sb
// - st_op        in   3   MemOp: 0 = sw, 6 = sh, 7 = sb; other codes are treated as sw
// - st_pc        in   32  PC of the store, carried to DM for the trace print
// - st_ready     out  1   high when the buffer can accept a store (= !full)
// - ld_valid     in   1   load in MEM stage this cycle
// - ld_addr      in   32  byte address of the load
// - ld_hazard    out  1   stall request: a pending entry overlaps the load word
// - ld_fwd_valid out  1   forwarded data valid; 0 when STORE_BUF_FWD_EN is undefined
// - ld_fwd_data  out  32  forwarded word; 0 when STORE_BUF_FWD_EN is undefined
// - dm_busy      in   1   DM port is used by a load this cycle; blocks the drain
// - dm_we        out  1   DM write enable
// - dm_addr      out  32  head entry address
// - dm_wd        out  32  head entry data
// - dm_op        out  3   head entry MemOp
// - dm_pc        out  32  head entry PC
// - empty        out  1   no pending entries
// BEHAVIOUR
// Storage and pointers
// - Circular FIFO with head/tail pointers of PTR_W bits that wrap modulo DEPTH, plus a count of PTR_W+1 bits.
// - full is count == DEPTH; empty is count == 0.
// Reset
// - On reset, head, tail and count clear to 0.
// - After reset: st_ready=1, empty=1, dm_we=0, ld_hazard=0, ld_fwd_valid=0.
// - Entry payloads need not clear.
// - Reset mid-drain discards all pending entries. No DM write occurs in the reset cycle.
// Enqueue
// - Condition: st_valid && st_ready.
// - Writes {addr, wd, op, pc} at tail, then tail++.
// - st_ready excludes a same-cycle drain (conservative), so a store presented while full is not accepted.
// - st_valid while full is a caller error; the request is dropped and the state is unchanged.
// Drain (combinational from head)
// - dm_we = !empty && !dm_busy; dm_addr/wd/op/pc = head entry.
// - The entry is retired at the clock edge where dm_we=1: head++.
// - When dm_we=0, the dm_* data outputs still show the head entry, or 0 when empty.
// - Minimum latency from enqueue to DM write is 1 cycle. A store accepted at edge N is written at edge N+1 if DM is free.
// Simultaneous enqueue and drain
// - count stays the same; both pointers advance.
// Ordering
// - Strict FIFO; drains happen in program order.
// Load hazard check (combinational)
// - A match is a valid entry with entry.addr[31:2] == ld_addr[31:2]. sh/sb entries match on the word, regardless of which bytes they write.
// - Only entries already in the buffer count. A store enqueued in the same cycle is not checked.
// - The check is gated by ld_valid; outputs are 0 when ld_valid=0.
// - Without fwd: ld_hazard=1 on any match.
// - With fwd: see CONFIGURATION.
// - While ld_hazard=1 the pipeline holds the load. dm_busy is low in that case, so the matching entries drain and the hazard clears.
// Arithmetic
// - Address compares are unsigned, full bits [31:2]; no address masking inside this block.
// CONFIGURATION
// - STORE_BUF_FWD_EN defined:
//   - Search entries youngest to oldest (tail-1 back to head) for a word match.
//   - If the youngest match has op==0 (sw): ld_fwd_valid=1, ld_fwd_data=entry.wd, ld_hazard=0.
//   - If the youngest match is sh/sb: ld_hazard=1, ld_fwd_valid=0.
//   - With no match, all three outputs are 0.
// - STORE_BUF_FWD_EN undefined:
//   - ld_fwd_valid and ld_fwd_data are tied to 0.
//   - Every match raises ld_hazard.
// TESTING
// - Reset, then check idle outputs: st_ready=1, empty=1, dm_we=0.
// - Single store: sw 0x0000_0010 <= 0xDEAD_BEEF with dm_busy=0. Required: next cycle dm_we=1, dm_addr=0x10, dm_wd=0xDEADBEEF; the following cycle empty=1.
// - Fill with dm_busy=1: 4 sw to 0x00/0x04/0x08/0x0C. Required: st_ready=0 after the 4th; a 5th st_valid is dropped.
//   Then release dm_busy. Required: 4 writes in order 0x00,0x04,0x08,0x0C on consecutive cycles; count 4->0; pointers wrap to 0.
// - Load hazard, fwd off: sb 0x0000_0021 pending, ld_valid with ld_addr=0x20. Required: ld_hazard=1 until the sb drains, then 0.
//   Load of 0x24 while 0x21 is pending: ld_hazard=0.
// - Forwarding, fwd on: sw 0x30 <= 0x1111_1111, then sw 0x30 <= 0x2222_2222, both pending. lw 0x30: ld_fwd_valid=1, ld_fwd_data=0x22222222, ld_hazard=0.
//   After adding sh 0x32 behind them: ld_hazard=1, ld_fwd_valid=0.
// - Simultaneous ops and reset: full buffer with st_valid and drain in the same cycle; the store is refused and count drops to 3.
//   Next, enqueue and drain together: count stays 3.
//   Assert reset with 3 pending: no dm_we in that cycle; afterwards empty=1.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: a DEPTH-entry FIFO between the MEM-stage store path and the data-memory write port.
// Define STORE_BUF_FWD_EN to forward data from a full-word store to a matching load.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_wd,
   input  logic [2:0]  st_op,
   input  logic [31:0] st_pc,
   output logic        st_ready,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   output logic        ld_hazard,
   output logic        ld_fwd_valid,
   output logic [31:0] ld_fwd_data,
   input  logic        dm_busy,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wd,
   output logic [2:0]  dm_op,
   output logic [31:0] dm_pc,
   output logic        empty
);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wd;
      logic [2:0]  op;
      logic [31:0] pc;
   } entry_t;

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_enq;
   logic             w_deq;
   entry_t           w_head_entry;
   logic             w_match_any;
   logic [PTR_W-1:0] w_idx;
   logic             w_unused;

   assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign st_ready = !w_full;
   assign empty    = w_empty;

   // st_ready ignores a same-cycle drain, so a full buffer refuses even when it is draining.
   assign w_enq = st_valid && !w_full;
   assign dm_we = !w_empty && !dm_busy && !reset;
   assign w_deq = dm_we;

   assign w_head_entry = w_empty ? '0 : r_mem[r_head];
   assign dm_addr      = w_head_entry.addr;
   assign dm_wd        = w_head_entry.wd;
   assign dm_op        = w_head_entry.op;
   assign dm_pc        = w_head_entry.pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) r_tail <= r_tail + 1'b1;
         if (w_deq) r_head <= r_head + 1'b1;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: the payload array is deliberately not reset; r_count alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (w_enq && !reset) r_mem[r_tail] <= {st_addr, st_wd, st_op, st_pc};
   end

`ifdef STORE_BUF_FWD_EN
   logic        w_young_sub;
   logic [31:0] w_young_wd;
`endif

   // Walk oldest to youngest so the last hit seen is the youngest matching store.
   always_comb begin
      w_match_any = 1'b0;
      w_idx       = r_head;
`ifdef STORE_BUF_FWD_EN
      w_young_sub = 1'b0;
      w_young_wd  = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_head + PTR_W'(k);
         if (((PTR_W+1)'(k) < r_count) && (r_mem[w_idx].addr[31:2] == ld_addr[31:2])) begin
            w_match_any = 1'b1;
`ifdef STORE_BUF_FWD_EN
            w_young_sub = (r_mem[w_idx].op == 3'd6) || (r_mem[w_idx].op == 3'd7);
            w_young_wd  = r_mem[w_idx].wd;
`endif
         end
      end
   end

`ifdef STORE_BUF_FWD_EN
   assign ld_hazard    = ld_valid && w_match_any && w_young_sub;
   assign ld_fwd_valid = ld_valid && w_match_any && !w_young_sub;
   assign ld_fwd_data  = ld_fwd_valid ? w_young_wd : '0;
`else
   assign ld_hazard    = ld_valid && w_match_any;
   assign ld_fwd_valid = 1'b0;
   assign ld_fwd_data  = '0;
`endif

   assign w_unused = &{1'b0, ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based model of the buffer.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_wd;
   logic [2:0]  st_op;
   logic [31:0] st_pc;
   logic        st_ready;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_hazard;
   logic        ld_fwd_valid;
   logic [31:0] ld_fwd_data;
   logic        dm_busy;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wd;
   logic [2:0]  dm_op;
   logic [31:0] dm_pc;
   logic        empty;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_addr(st_addr), .st_wd(st_wd), .st_op(st_op), .st_pc(st_pc),
      .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr),
      .ld_hazard(ld_hazard), .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
      .dm_busy(dm_busy), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_op(dm_op),
      .dm_pc(dm_pc), .empty(empty)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wd;
      logic [2:0]  op;
      logic [31:0] pc;
   } ent_t;

   ent_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Expected outputs derived from the pending-store queue and the current inputs.
   task automatic check_outputs();
      ent_t        h;
      logic        found;
      logic        sub;
      logic [31:0] data;
      logic        e_hz;
      logic        e_fv;
      logic [31:0] e_fd;
      h     = '{default: '0};
      found = 1'b0;
      sub   = 1'b0;
      data  = '0;
      if (q.size() > 0) h = q[0];
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (!found && q[i].addr[31:2] == ld_addr[31:2]) begin
            found = 1'b1;
            sub   = (q[i].op == 3'd6) || (q[i].op == 3'd7);
            data  = q[i].wd;
         end
      end
`ifdef STORE_BUF_FWD_EN
      e_hz = ld_valid && found && sub;
      e_fv = ld_valid && found && !sub;
      e_fd = e_fv ? data : 32'h0;
`else
      e_hz = ld_valid && found;
      e_fv = 1'b0;
      e_fd = 32'h0;
`endif
      check("st_ready", {31'b0, st_ready}, {31'b0, q.size() < 4});
      check("empty", {31'b0, empty}, {31'b0, q.size() == 0});
      check("dm_we", {31'b0, dm_we}, {31'b0, (q.size() > 0) && !dm_busy && !reset});
      check("dm_addr", dm_addr, h.addr);
      check("dm_wd", dm_wd, h.wd);
      check("dm_op", {29'b0, dm_op}, {29'b0, h.op});
      check("dm_pc", dm_pc, h.pc);
      check("ld_hazard", {31'b0, ld_hazard}, {31'b0, e_hz});
      check("ld_fwd_valid", {31'b0, ld_fwd_valid}, {31'b0, e_fv});
      check("ld_fwd_data", ld_fwd_data, e_fd);
   endtask

   task automatic model_update();
      logic drain;
      logic enq;
      if (reset) begin
         q.delete();
      end else begin
         drain = (q.size() > 0) && !dm_busy;
         enq   = st_valid && (q.size() < 4);
         if (drain) void'(q.pop_front());
         if (enq) q.push_back('{addr: st_addr, wd: st_wd, op: st_op, pc: st_pc});
      end
   endtask

   task automatic cycle();
      #2;
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
      st_valid = v;
      st_addr  = a;
      st_wd    = d;
      st_op    = op;
      st_pc    = 32'h0040_0000 + a;
   endtask

   initial begin
      reset    = 1'b1;
      ld_valid = 1'b0;
      ld_addr  = '0;
      dm_busy  = 1'b0;
      set_st(1'b0, 32'h0, 32'h0, 3'd0);
      cycle();
      cycle();
      reset = 1'b0;
      #1;
      check("idle_st_ready", {31'b0, st_ready}, 32'd1);
      check("idle_empty", {31'b0, empty}, 32'd1);
      check("idle_dm_we", {31'b0, dm_we}, 32'd0);
      cycle();

      // Single store written one cycle after acceptance.
      set_st(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'd0);
      cycle();
      set_st(1'b0, 32'h0, 32'h0, 3'd0);
      #1;
      check("single_we", {31'b0, dm_we}, 32'd1);
      check("single_addr", dm_addr, 32'h10);
      check("single_wd", dm_wd, 32'hDEAD_BEEF);
      cycle();
      #1;
      check("single_empty", {31'b0, empty}, 32'd1);

      // Fill with DM busy, drop a fifth store, then drain in order.
      dm_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_st(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 3'd0);
         cycle();
      end
      #1;
      check("full_st_ready", {31'b0, st_ready}, 32'd0);
      set_st(1'b1, 32'h40, 32'hFFFF_FFFF, 3'd0);
      cycle();
      set_st(1'b0, 32'h0, 32'h0, 3'd0);
      dm_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_we", {31'b0, dm_we}, 32'd1);
         check("drain_addr", dm_addr, 32'(i * 4));
         cycle();
      end
      #1;
      check("drain_empty", {31'b0, empty}, 32'd1);

      // Byte store pending against a load of the same word, then a different word.
      dm_busy = 1'b1;
      set_st(1'b1, 32'h21, 32'h0000_00AB, 3'd7);
      cycle();
      set_st(1'b0, 32'h0, 32'h0, 3'd0);
      ld_valid = 1'b1;
      ld_addr  = 32'h20;
      #1;
      check("sb_hazard", {31'b0, ld_hazard}, 32'd1);
      cycle();
      ld_addr = 32'h24;
      #1;
      check("sb_other_word", {31'b0, ld_hazard}, 32'd0);
      cycle();
      ld_addr = 32'h20;
      dm_busy = 1'b0;
      #1;
      check("sb_hazard_hold", {31'b0, ld_hazard}, 32'd1);
      cycle();
      #1;
      check("sb_hazard_clear", {31'b0, ld_hazard}, 32'd0);
      ld_valid = 1'b0;
      cycle();

      // Two word stores to one address, then a halfword behind them.
      dm_busy = 1'b1;
      set_st(1'b1, 32'h30, 32'h1111_1111, 3'd0);
      cycle();
      set_st(1'b1, 32'h30, 32'h2222_2222, 3'd0);
      cycle();
      set_st(1'b0, 32'h0, 32'h0, 3'd0);
      ld_valid = 1'b1;
      ld_addr  = 32'h30;
      #1;
`ifdef STORE_BUF_FWD_EN
      check("fwd_valid", {31'b0, ld_fwd_valid}, 32'd1);
      check("fwd_data", ld_fwd_data, 32'h2222_2222);
      check("fwd_no_hazard", {31'b0, ld_hazard}, 32'd0);
`else
      check("nofwd_hazard", {31'b0, ld_hazard}, 32'd1);
      check("nofwd_valid", {31'b0, ld_fwd_valid}, 32'd0);
`endif
      cycle();
      set_st(1'b1, 32'h32, 32'h0000_3333, 3'd6);
      cycle();
      set_st(1'b0, 32'h0, 32'h0, 3'd0);
      #1;
      check("sh_hazard", {31'b0, ld_hazard}, 32'd1);
      check("sh_no_fwd", {31'b0, ld_fwd_valid}, 32'd0);
      cycle();
      ld_valid = 1'b0;
      dm_busy  = 1'b0;
      for (int i = 0; i < 4; i++) cycle();

      // Full buffer with store and drain together, then enqueue+drain, then reset mid-drain.
      dm_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_st(1'b1, 32'h100 + 32'(i * 4), 32'hB000_0000 + 32'(i), 3'd0);
         cycle();
      end
      set_st(1'b1, 32'h200, 32'hC0C0_C0C0, 3'd0);
      dm_busy = 1'b0;
      cycle();
      #1;
      check("refused_st_ready", {31'b0, st_ready}, 32'd1);
      check("refused_head", dm_addr, 32'h104);
      set_st(1'b1, 32'h204, 32'hC1C1_C1C1, 3'd0);
      cycle();
      set_st(1'b0, 32'h0, 32'h0, 3'd0);
      check("count3_head", dm_addr, 32'h108);
      reset = 1'b1;
      #1;
      check("reset_no_we", {31'b0, dm_we}, 32'd0);
      cycle();
      reset = 1'b0;
      #1;
      check("reset_empty", {31'b0, empty}, 32'd1);
      cycle();

      // Random traffic over a small address window so loads often hit pending stores.
      for (int n = 0; n < 400; n++) begin
         logic [2:0] ops [4];
         ops[0] = 3'd0;
         ops[1] = 3'd6;
         ops[2] = 3'd7;
         ops[3] = 3'd3;
         reset    = ($urandom_range(0, 59) == 0);
         dm_busy  = ($urandom_range(0, 2) == 0);
         ld_valid = $urandom_range(0, 1);
         ld_addr  = 32'($urandom_range(0, 31));
         set_st(1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom, ops[$urandom_range(0, 3)]);
         cycle();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
